// File: rtl/keyscan_pkg.sv
// keyscan_pkg: shared types and helpers for the matrix keypad scanner.
package keyscan_pkg;

    // Accept state: no key owned, or one key currently held.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    // Result of looking at one complete scan frame.
    typedef enum logic [1:0] {
        CL_NONE   = 2'd0,
        CL_SINGLE = 2'd1,
        CL_MULTI  = 2'd2
    } cls_t;

    // Width of a key code row*cols+col.
    function automatic int code_w(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

endpackage

// File: rtl/keyscan_fifo.sv
// keyscan_fifo: small synchronous FIFO for accepted key codes.
// Push and pop may coincide while full; the push then still lands.
module keyscan_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                   ck,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop_rdy,
    output logic [W-1:0]           dout,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_r;
    logic [AW-1:0] rd_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_n_s;
    logic          valid_r;
    logic          full_s;
    logic          pop_s;
    logic          push_ok_s;

    assign full_s    = (count_r == CW'(DEPTH));
    assign pop_s     = pop_rdy && valid_r;
    assign push_ok_s = push && (!full_s || pop_s);

    // Occupancy after this cycle's push and pop.
    always_comb begin
        count_n_s = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_n_s = count_r + CW'(1'b1);
            2'b01:   count_n_s = count_r - CW'(1'b1);
            default: count_n_s = count_r;
        endcase
    end

    // Storage, pointers and occupancy; reset discards every queued code.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_r    <= '0;
            rd_r    <= '0;
            count_r <= '0;
            valid_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_r] <= din;
                wr_r        <= wr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_r <= rd_r + AW'(1'b1);
            end
            count_r <= count_n_s;
            valid_r <= (count_n_s != '0);
        end
    end

    assign dout  = mem_r[rd_r];
    assign valid = valid_r;
    assign count = count_r;
    assign full  = full_s;
    assign drop  = push && !push_ok_s;

endmodule

// File: rtl/keyscan_matrix.sv
// keyscan_matrix: row-strobed keypad scanner with whole-frame debounce,
// multi-key rejection, rollover and a key-code FIFO.
// Optional auto-repeat while a key is held: define KEYSCAN_REPEAT_EN.
module keyscan_matrix
    import keyscan_pkg::*;
#(
    parameter int ROWS       = 3,
    parameter int COLS       = 4,
    parameter int CLK_DIV    = 64,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 4
`ifdef KEYSCAN_REPEAT_EN
    ,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4
`endif
) (
    input  logic                          ck,
    input  logic                          reset,
    input  logic [COLS-1:0]               colin,
    output logic [ROWS-1:0]               rowout,
    output logic [code_w(ROWS, COLS)-1:0] keycode,
    output logic                          keyvalid,
    input  logic                          keyready,
    output logic                          keydown,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    input  logic                          ovf_clr
);
    localparam int CODE_W = code_w(ROWS, COLS);
    localparam int NBITS  = ROWS * COLS;
    localparam int PW     = $clog2(CLK_DIV);
    localparam int RW     = $clog2(ROWS);
    localparam int DW     = $clog2(DEBOUNCE + 1);

    logic [COLS-1:0]   sync1_r;
    logic [COLS-1:0]   sync2_r;
    logic [PW-1:0]     presc_r;
    logic [RW-1:0]     row_r;
    logic [ROWS-1:0]   rowout_r;
    logic [NBITS-1:0]  frame_r;
    logic [NBITS-1:0]  frame_s;
    logic              step_end_s;
    logic              frame_end_s;
    logic [1:0]        ones_s;
    cls_t              cls_s;
    cls_t              prev_cls_r;
    logic [CODE_W-1:0] code_s;
    logic [CODE_W-1:0] prev_code_r;
    logic [DW-1:0]     stab_r;
    logic [DW-1:0]     stab_n_s;
    logic              stable_s;
    state_t            state_r;
    state_t            state_n_s;
    logic [CODE_W-1:0] held_r;
    logic [CODE_W-1:0] held_n_s;
    logic              keydown_r;
    logic              push_s;
    logic [CODE_W-1:0] push_code_s;
    logic              fifo_full_s;
    logic              fifo_drop_s;
    logic              overflow_r;

`ifdef KEYSCAN_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPW  = $clog2(RMAX + 1);

    logic [RPW-1:0] rep_r;
    logic [RPW-1:0] rep_n_s;
    logic [RPW-1:0] rep_inc_s;
    logic [RPW-1:0] rep_tgt_s;
    logic           rep_first_r;
    logic           rep_first_n_s;

    assign rep_inc_s = rep_r + RPW'(1'b1);
    assign rep_tgt_s = rep_first_r ? RPW'(REPEAT_DELAY) : RPW'(REPEAT_RATE);
`endif

    // Two-flop synchroniser for the asynchronous column inputs.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= colin;
            sync2_r <= sync1_r;
        end
    end

    assign step_end_s  = (presc_r == PW'(CLK_DIV - 1));
    assign frame_end_s = step_end_s && (row_r == RW'(ROWS - 1));

    // Prescaler, row index and one-hot row drive advance together.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            presc_r  <= '0;
            row_r    <= '0;
            rowout_r <= {{(ROWS-1){1'b0}}, 1'b1};
        end else if (step_end_s) begin
            presc_r  <= '0;
            row_r    <= frame_end_s ? '0 : (row_r + RW'(1'b1));
            rowout_r <= {rowout_r[ROWS-2:0], rowout_r[ROWS-1]};
        end else begin
            presc_r  <= presc_r + PW'(1'b1);
        end
    end

    // Frame image with the current row's columns merged in, so the frame
    // can be classified in the very cycle its last row is sampled.
    always_comb begin
        frame_s = frame_r;
        for (int r = 0; r < ROWS; r++) begin
            if (row_r == RW'(r)) begin
                frame_s[r*COLS +: COLS] = sync2_r;
            end else begin
                frame_s[r*COLS +: COLS] = frame_r[r*COLS +: COLS];
            end
        end
    end

    // Latch the sampled columns at the last prescaler cycle of each row.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            frame_r <= '0;
        end else if (step_end_s) begin
            frame_r <= frame_s;
        end else begin
            frame_r <= frame_r;
        end
    end

    // Classify the frame: count set bits (saturating at two) and keep the lowest code.
    always_comb begin
        ones_s = 2'd0;
        code_s = '0;
        cls_s  = CL_NONE;
        for (int i = 0; i < NBITS; i++) begin
            if (frame_s[i] && (ones_s == 2'd0)) begin
                code_s = CODE_W'(i);
                ones_s = 2'd1;
            end else if (frame_s[i]) begin
                ones_s = 2'd2;
            end else begin
                ones_s = ones_s;
            end
        end
        case (ones_s)
            2'd0:    cls_s = CL_NONE;
            2'd1:    cls_s = CL_SINGLE;
            default: cls_s = CL_MULTI;
        endcase
    end

    // Stability count for this frame; multi-key frames never build stability.
    always_comb begin
        stab_n_s = DW'(1'b1);
        if (cls_s == CL_MULTI) begin
            stab_n_s = DW'(1'b1);
        end else if ((cls_s == prev_cls_r) && ((cls_s == CL_NONE) || (code_s == prev_code_r))) begin
            if (stab_r == DW'(DEBOUNCE)) begin
                stab_n_s = stab_r;
            end else begin
                stab_n_s = stab_r + DW'(1'b1);
            end
        end else begin
            stab_n_s = DW'(1'b1);
        end
    end

    assign stable_s = frame_end_s && (cls_s != CL_MULTI) && (stab_n_s == DW'(DEBOUNCE));

    // Remember the previous frame's classification and its stability count.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            prev_cls_r  <= CL_NONE;
            prev_code_r <= '0;
            stab_r      <= '0;
        end else if (frame_end_s) begin
            prev_cls_r  <= cls_s;
            prev_code_r <= code_s;
            stab_r      <= stab_n_s;
        end else begin
            stab_r      <= stab_r;
        end
    end

    // Accept FSM next state and push requests (press, rollover, repeat).
    always_comb begin
        state_n_s   = state_r;
        held_n_s    = held_r;
        push_s      = 1'b0;
        push_code_s = code_s;
`ifdef KEYSCAN_REPEAT_EN
        rep_n_s       = rep_r;
        rep_first_n_s = rep_first_r;
`endif
        if (stable_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (cls_s == CL_SINGLE) begin
                        push_s    = 1'b1;
                        state_n_s = ST_HELD;
                        held_n_s  = code_s;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (cls_s == CL_NONE) begin
                        state_n_s = ST_IDLE;
                    end else if (code_s != held_r) begin
                        push_s   = 1'b1;
                        held_n_s = code_s;
                    end else begin
                        state_n_s = ST_HELD;
                    end
                end
                default: state_n_s = ST_IDLE;
            endcase
        end else begin
            state_n_s = state_r;
        end
`ifdef KEYSCAN_REPEAT_EN
        if (frame_end_s && (state_r == ST_HELD)) begin
            if ((cls_s == CL_SINGLE) && (code_s == held_r)) begin
                if (rep_inc_s == rep_tgt_s) begin
                    push_s        = 1'b1;
                    rep_n_s       = '0;
                    rep_first_n_s = 1'b0;
                end else begin
                    rep_n_s       = rep_inc_s;
                    rep_first_n_s = rep_first_r;
                end
            end else begin
                rep_n_s       = '0;
                rep_first_n_s = 1'b1;
            end
        end else if (state_r == ST_IDLE) begin
            rep_n_s       = '0;
            rep_first_n_s = 1'b1;
        end else begin
            rep_n_s       = rep_r;
            rep_first_n_s = rep_first_r;
        end
`endif
    end

    // Accept FSM state register and the registered keydown level.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            held_r      <= '0;
            keydown_r   <= 1'b0;
`ifdef KEYSCAN_REPEAT_EN
            rep_r       <= '0;
            rep_first_r <= 1'b1;
`endif
        end else begin
            state_r     <= state_n_s;
            held_r      <= held_n_s;
            keydown_r   <= (state_n_s == ST_HELD);
`ifdef KEYSCAN_REPEAT_EN
            rep_r       <= rep_n_s;
            rep_first_r <= rep_first_n_s;
`endif
        end
    end

    keyscan_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CODE_W)
    ) u_fifo (
        .ck      (ck),
        .reset   (reset),
        .push    (push_s),
        .din     (push_code_s),
        .pop_rdy (keyready),
        .dout    (keycode),
        .valid   (keyvalid),
        .count   (count),
        .full    (fifo_full_s),
        .drop    (fifo_drop_s)
    );

    // Sticky overflow: a drop (only possible while full) wins over a clear.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (fifo_drop_s && fifo_full_s) begin
            overflow_r <= 1'b1;
        end else if (ovf_clr) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign rowout   = rowout_r;
    assign keydown  = keydown_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_keyscan_matrix.sv
// tb_keyscan_matrix: directed keypad scenarios against a frame-level model.
module tb_keyscan_matrix;
    localparam int ROWS  = 3;
    localparam int COLS  = 4;
    localparam int CDIV  = 4;
    localparam int DEB   = 2;
    localparam int DEPTH = 4;
    localparam int FRAME = ROWS * CDIV;
`ifdef KEYSCAN_REPEAT_EN
    localparam int RDELAY = 3;
    localparam int RRATE  = 2;
`endif

    logic        ck = 1'b0;
    logic        reset = 1'b1;
    logic        keyready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [11:0] keys = 12'h000;
    logic [3:0]  colin;
    logic [2:0]  rowout;
    logic [3:0]  keycode;
    logic        keyvalid;
    logic        keydown;
    logic [2:0]  count;
    logic        overflow;

    int vectors = 0;
    int errors  = 0;

    keyscan_matrix #(
        .ROWS(ROWS), .COLS(COLS), .CLK_DIV(CDIV), .DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH)
`ifdef KEYSCAN_REPEAT_EN
        , .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)
`endif
    ) dut (
        .ck(ck), .reset(reset), .colin(colin), .rowout(rowout), .keycode(keycode),
        .keyvalid(keyvalid), .keyready(keyready), .keydown(keydown), .count(count),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 ck = ~ck;

    // Keypad: a pressed key closes its column while its row is driven.
    always_comb begin
        colin = 4'b0000;
        for (int r = 0; r < ROWS; r++) begin
            if (rowout[r]) colin = colin | keys[r*COLS +: COLS];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    int mq[$];     // expected FIFO contents
    int hist[$];   // last DEB frame classifications
    bit m_held;
    int m_code;
    int run;
    bit m_ovf;
    int cyc;

    // -1 = no key, -2 = several keys, otherwise the single key code.
    function automatic int classify(input logic [11:0] k);
        int n;
        n = $countones(k);
        if (n == 0) return -1;
        if (n > 1) return -2;
        for (int i = 0; i < 12; i++) if (k[i]) return i;
        return -1;
    endfunction

    always @(posedge ck or posedge reset) begin : model
        bit drop;
        bit stable;
        bit was_held;
        int c;
        int old;
        int push;
        if (reset) begin
            mq.delete();
            hist.delete();
            m_held = 1'b0;
            m_code = 0;
            run    = 0;
            m_ovf  = 1'b0;
            cyc    = 0;
        end else begin
            drop = 1'b0;
            if (keyready && mq.size() > 0) void'(mq.pop_front());
            if (cyc % FRAME == FRAME - 1) begin
                c = classify(keys);
                hist.push_back(c);
                if (hist.size() > DEB) void'(hist.pop_front());
                stable = (hist.size() == DEB) && (c != -2);
                foreach (hist[i]) if (hist[i] != c) stable = 1'b0;
                was_held = m_held;
                old      = m_code;
                push     = -1;
                if (stable && !m_held && c >= 0) begin
                    push = c; m_held = 1'b1; m_code = c; run = 0;
                end else if (stable && m_held && c == -1) begin
                    m_held = 1'b0;
                end else if (stable && m_held && c >= 0 && c != m_code) begin
                    push = c; m_code = c; run = 0;
                end
`ifdef KEYSCAN_REPEAT_EN
                if (was_held && c == old) begin
                    run++;
                    if (run == RDELAY || (run > RDELAY && (run - RDELAY) % RRATE == 0)) push = old;
                end else begin
                    run = 0;
                end
`else
                if (was_held && c == old) run++;
                else run = 0;
`endif
                if (push >= 0) begin
                    if (mq.size() < DEPTH) mq.push_back(push);
                    else drop = 1'b1;
                end
            end
            if (drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            cyc++;
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge ck) begin
        if (!reset) begin
            chk("rowout", rowout, 3'b001 << ((cyc / CDIV) % ROWS));
            chk("keyvalid", keyvalid, mq.size() > 0);
            chk("count", count, mq.size());
            if (mq.size() > 0) chk("keycode", keycode, mq[0]);
            chk("keydown", keydown, m_held);
            chk("overflow", overflow, m_ovf);
        end
    end

    // One scan frame with a fixed key set; optional pop / clear cycle.
    task automatic frame(input logic [11:0] k, input int popc = -1, input int clrc = -1);
        keys = k;
        for (int c = 0; c < FRAME; c++) begin
            keyready = (c == popc);
            ovf_clr  = (c == clrc);
            @(posedge ck);
            #1;
        end
        keyready = 1'b0;
        ovf_clr  = 1'b0;
    endtask

    task automatic press(input int code);
        logic [11:0] k;
        k = 12'h001 << code;
        frame(k);
        frame(k);
        frame(12'h000);
        frame(12'h000);
    endtask

    initial begin
        int seq[5];
        seq = '{1, 2, 4, 8, 9};
        reset = 1'b1;
        keys  = 12'h000;
        repeat (3) @(posedge ck);
        #1;
        chk("rst_rowout", rowout, 3'b001);
        chk("rst_keyvalid", keyvalid, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_keydown", keydown, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        reset = 1'b0;

        // single press of key 6 (row 1, column 2)
        frame(12'h000);
        frame(12'h040);
        frame(12'h040);
        chk("press_keydown", keydown, 1'b1);
        chk("press_count", count, 3'd1);
        chk("press_code", keycode, 4'd6);
        chk("model_q_len", mq.size(), 1);
        frame(12'h040);
        frame(12'h000);
        frame(12'h000);
        chk("release_keydown", keydown, 1'b0);
        chk("release_count", count, 3'd1);
        frame(12'h000, 3);
        chk("pop_count", count, 3'd0);

        // multi-key and bounce rejection
        repeat (3) frame(12'h021);
        repeat (2) frame(12'h000);
        chk("multi_count", count, 3'd0);
        repeat (3) begin
            frame(12'h008);
            frame(12'h000);
        end
        chk("bounce_count", count, 3'd0);
        chk("bounce_keydown", keydown, 1'b0);

        // fill past capacity
        foreach (seq[i]) press(seq[i]);
        chk("ovf_count", count, 3'd4);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_head", keycode, 4'd1);
        frame(12'h400);
        frame(12'h400, FRAME - 1);
        chk("pushpop_count", count, 3'd4);
        chk("pushpop_head", keycode, 4'd2);
        frame(12'h800);
        frame(12'h800, -1, FRAME - 1);
        chk("setwins_ovf", overflow, 1'b1);
        chk("setwins_count", count, 3'd4);
        frame(12'h000, -1, 3);
        chk("clr_ovf", overflow, 1'b0);
        frame(12'h000, 2);
        frame(12'h000, 2);
        chk("two_left_count", count, 3'd2);
        chk("two_left_head", keycode, 4'd8);

        // asynchronous reset in the middle of a frame
        repeat (5) @(posedge ck);
        #2;
        reset = 1'b1;
        #1;
        chk("async_count", count, 3'd0);
        chk("async_keyvalid", keyvalid, 1'b0);
        chk("async_rowout", rowout, 3'b001);
        @(posedge ck);
        @(posedge ck);
        #1;
        reset = 1'b0;
        press(7);
        chk("after_rst_count", count, 3'd1);
        chk("after_rst_code", keycode, 4'd7);
        frame(12'h000, 2);

        // long hold of key 11
        repeat (10) frame(12'h800);
`ifdef KEYSCAN_REPEAT_EN
        chk("hold_count", count, 3'd4);
`else
        chk("hold_count", count, 3'd1);
`endif
        chk("hold_code", keycode, 4'd11);
        chk("hold_keydown", keydown, 1'b1);
        frame(12'h000);
        frame(12'h000);
        chk("final_keydown", keydown, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
